// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if: decoder-side and pipeline-side signals of the exception
// control unit. The slave modport is the unit itself; the master modport is
// the surrounding pipeline (decoder, PC mux, pipeline registers).
interface exc_ctrl_if #(
  parameter int N = 64
);
  logic         Valid;
  logic [N-1:0] PC_D;
  logic [3:0]   EStatus;
  logic         ERet;
  logic         NotAnInstr;
  logic         ExtIRQ;
  logic         Exc;
  logic [N-1:0] ExcVector;
  logic [N-1:0] ELR_out;
  logic [3:0]   ESR_out;
  logic         Flush;
  logic         IRQAck;
  logic         InHandler;
  logic         Halted;

  modport slave (
    input  Valid, PC_D, EStatus, ERet, NotAnInstr, ExtIRQ,
    output Exc, ExcVector, ELR_out, ESR_out, Flush, IRQAck, InHandler, Halted
  );

  modport master (
    output Valid, PC_D, EStatus, ERet, NotAnInstr, ExtIRQ,
    input  Exc, ExcVector, ELR_out, ESR_out, Flush, IRQAck, InHandler, Halted
  );
endinterface

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception control unit sitting after the main decoder.
// Captures the faulting / interrupted PC into ELR and the cause into ESR,
// pulses Exc to steer fetch to EXC_VECTOR, holds Flush for FLUSH_CYCLES
// cycles, then tracks handler mode until ERET. A fault inside the handler
// locks the unit in HALT until reset.
// Optional build macro EXC_IRQ_SYNC_EN: when defined, ExtIRQ goes through a
// two-flop synchronizer before reaching the pending-interrupt logic.
module exc_ctrl #(
  parameter int           N            = 64,
  parameter logic [N-1:0] EXC_VECTOR   = 64'h0000_0000_0000_00D8,
  parameter int           FLUSH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  exc_ctrl_if.slave     if_exc
);

  localparam logic [2:0] S_RUN     = 3'd0;
  localparam logic [2:0] S_TAKE    = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_HANDLER = 3'd3;
  localparam logic [2:0] S_HALT    = 3'd4;

  // Counter preload on entry; zero means TAKE goes straight to HANDLER.
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  localparam logic [3:0] ESR_NONE   = 4'b0000;
  localparam logic [3:0] ESR_IRQ    = 4'b0001;
  localparam logic [3:0] ESR_INVOP  = 4'b0010;
  localparam logic [3:0] ESR_DOUBLE = 4'b0011;

  logic [2:0]   r_state;
  logic [2:0]   r_cnt;
  logic [N-1:0] r_elr;
  logic [3:0]   r_esr;
  logic         r_pend;
  logic         r_irq_take;
  logic         r_exc;
  logic         r_flush;
  logic         r_irqack;
  logic         r_inhandler;
  logic         r_halted;

  logic [2:0]   w_state_nxt;
  logic [2:0]   w_cnt_nxt;
  logic [N-1:0] w_elr_nxt;
  logic [3:0]   w_esr_nxt;
  logic         w_pend_nxt;
  logic         w_irq_take_nxt;
  logic         w_irq_in;
  logic         w_sync_fault;
  logic         w_bad_op;
  logic         w_eret;

`ifdef EXC_IRQ_SYNC_EN
  logic r_irq_s1;
  logic r_irq_s2;

  // Two-flop synchronizer for the asynchronous interrupt line.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_s1 <= 1'b0;
      r_irq_s2 <= 1'b0;
    end else begin
      r_irq_s1 <= if_exc.ExtIRQ;
      r_irq_s2 <= r_irq_s1;
    end
  end

  assign w_irq_in = r_irq_s2;
`else
  assign w_irq_in = if_exc.ExtIRQ;
`endif

  // Decoder flags only count for real (non-bubble) instructions.
  assign w_bad_op     = if_exc.Valid & if_exc.NotAnInstr;
  assign w_eret       = if_exc.Valid & if_exc.ERet;
  // ERET outside the handler is treated as an invalid opcode.
  assign w_sync_fault = w_bad_op | w_eret;

  // Next-state, capture-register and pending-interrupt logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_elr_nxt      = r_elr;
    w_esr_nxt      = r_esr;
    w_pend_nxt     = r_pend;
    w_irq_take_nxt = r_irq_take;
    case (r_state)
      S_RUN: begin
        // Interrupt lines are only sampled here; a coincident fault keeps it pending.
        w_pend_nxt = r_pend | w_irq_in;
        if (w_sync_fault) begin
          w_elr_nxt      = if_exc.PC_D;
          w_esr_nxt      = w_bad_op ? if_exc.EStatus : ESR_INVOP;
          w_irq_take_nxt = 1'b0;
          w_state_nxt    = S_TAKE;
        end else if (r_pend) begin
          // The interrupted instruction is re-executed after ERET.
          w_elr_nxt      = if_exc.PC_D;
          w_esr_nxt      = ESR_IRQ;
          w_irq_take_nxt = 1'b1;
          w_pend_nxt     = 1'b0;
          w_state_nxt    = S_TAKE;
        end else begin
          w_irq_take_nxt = 1'b0;
        end
      end
      S_TAKE: begin
        w_cnt_nxt   = FLUSH_INIT;
        w_state_nxt = (FLUSH_INIT == 3'd0) ? S_HANDLER : S_DRAIN;
      end
      S_DRAIN: begin
        if (r_cnt <= 3'd1) begin
          w_cnt_nxt   = 3'd0;
          w_state_nxt = S_HANDLER;
        end else begin
          w_cnt_nxt   = r_cnt - 3'd1;
        end
      end
      S_HANDLER: begin
        if (w_bad_op) begin
          w_esr_nxt   = ESR_DOUBLE;
          w_state_nxt = S_HALT;
        end else if (w_eret) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_HANDLER;
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  // State, capture registers and Moore outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_cnt       <= 3'd0;
      r_elr       <= '0;
      r_esr       <= ESR_NONE;
      r_pend      <= 1'b0;
      r_irq_take  <= 1'b0;
      r_exc       <= 1'b0;
      r_flush     <= 1'b0;
      r_irqack    <= 1'b0;
      r_inhandler <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_elr       <= w_elr_nxt;
      r_esr       <= w_esr_nxt;
      r_pend      <= w_pend_nxt;
      r_irq_take  <= w_irq_take_nxt;
      r_exc       <= (w_state_nxt == S_TAKE);
      r_flush     <= (w_state_nxt == S_TAKE) || (w_state_nxt == S_DRAIN) ||
                     (w_state_nxt == S_HALT);
      r_irqack    <= (w_state_nxt == S_TAKE) && w_irq_take_nxt;
      r_inhandler <= (w_state_nxt == S_HANDLER);
      r_halted    <= (w_state_nxt == S_HALT);
    end
  end

  assign if_exc.Exc       = r_exc;
  assign if_exc.ExcVector = EXC_VECTOR;
  assign if_exc.ELR_out   = r_elr;
  assign if_exc.ESR_out   = r_esr;
  assign if_exc.Flush     = r_flush;
  assign if_exc.IRQAck    = r_irqack;
  assign if_exc.InHandler = r_inhandler;
  assign if_exc.Halted    = r_halted;

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed scenarios followed by random stimulus, all outputs
// compared every cycle against a timeline-style reference model.
module tb_exc_ctrl;
  localparam int FLUSH = 2;
`ifdef EXC_IRQ_SYNC_EN
  localparam int IRQ_EXTRA = 2;
`else
  localparam int IRQ_EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  exc_ctrl_if #(.N(64)) bus();

  exc_ctrl #(
    .N(64),
    .EXC_VECTOR(64'h0000_0000_0000_00D8),
    .FLUSH_CYCLES(FLUSH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .if_exc(bus)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 = running, 1 = inside an exception (m_age counts
  // cycles since the Exc cycle), 2 = locked after a double fault.
  int          m_mode = 0;
  int          m_age  = 0;
  bit          m_irqc = 1'b0;
  bit          m_pend = 1'b0;
  bit          m_d1   = 1'b0;
  bit          m_d2   = 1'b0;
  logic [63:0] m_elr  = 64'd0;
  logic [3:0]  m_esr  = 4'd0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_tick();
    bit eff;
    bit took;
    if (reset) begin
      m_mode = 0; m_age = 0; m_irqc = 1'b0; m_pend = 1'b0;
      m_d1 = 1'b0; m_d2 = 1'b0; m_elr = 64'd0; m_esr = 4'd0;
    end else begin
`ifdef EXC_IRQ_SYNC_EN
      eff  = m_d2;
      m_d2 = m_d1;
      m_d1 = bus.ExtIRQ;
`else
      eff  = bus.ExtIRQ;
`endif
      took = 1'b0;
      if (m_mode == 0) begin
        if (bus.Valid && (bus.NotAnInstr || bus.ERet)) begin
          m_elr  = bus.PC_D;
          m_esr  = bus.NotAnInstr ? bus.EStatus : 4'd2;
          m_irqc = 1'b0;
          m_mode = 1;
          m_age  = 0;
        end else if (m_pend) begin
          m_elr  = bus.PC_D;
          m_esr  = 4'd1;
          m_irqc = 1'b1;
          m_mode = 1;
          m_age  = 0;
          took   = 1'b1;
        end
        m_pend = took ? 1'b0 : (m_pend | eff);
      end else if (m_mode == 1) begin
        if (m_age < FLUSH) m_age++;
        else if (bus.Valid && bus.NotAnInstr) begin
          m_mode = 2;
          m_esr  = 4'd3;
        end else if (bus.Valid && bus.ERet) m_mode = 0;
      end
    end
  endtask

  task automatic compare_all();
    bit e_exc;
    e_exc = (m_mode == 1) && (m_age == 0);
    check_eq("Exc", bus.Exc, e_exc);
    check_eq("Flush", bus.Flush, (m_mode == 2) || ((m_mode == 1) && (m_age < FLUSH)));
    check_eq("IRQAck", bus.IRQAck, e_exc && m_irqc);
    check_eq("InHandler", bus.InHandler, (m_mode == 1) && (m_age >= FLUSH));
    check_eq("Halted", bus.Halted, m_mode == 2);
    check_eq("ELR", bus.ELR_out, m_elr);
    check_eq("ESR", bus.ESR_out, m_esr);
    check_eq("ExcVector", bus.ExcVector, 64'h0000_0000_0000_00D8);
  endtask

  // One clock: drive inputs, advance model at the edge, compare at the negedge.
  task automatic step(input bit rst, input bit v, input logic [63:0] pc, input logic [3:0] est,
                      input bit eret, input bit nai, input bit irq);
    reset = rst;
    bus.Valid = v; bus.PC_D = pc; bus.EStatus = est;
    bus.ERet = eret; bus.NotAnInstr = nai; bus.ExtIRQ = irq;
    @(posedge clk);
    model_tick();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input logic [63:0] pc, input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, pc, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit r, v, er, na, iq;
    step(1'b1, 1'b0, 64'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 64'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_esr", bus.ESR_out, 64'd0);

    // Invalid opcode at 0x40.
    step(1'b0, 1'b1, 64'h40, 4'd2, 1'b0, 1'b1, 1'b0);
    check_eq("inv_exc", bus.Exc, 64'd1);
    check_eq("inv_elr", bus.ELR_out, 64'h40);
    check_eq("inv_esr", bus.ESR_out, 64'd2);
    idle(64'h44, 1);
    check_eq("inv_flush2", bus.Flush, 64'd1);
    idle(64'h48, 1);
    check_eq("inv_inh", bus.InHandler, 64'd1);
    check_eq("inv_flush_off", bus.Flush, 64'd0);

    // ERET from the handler.
    step(1'b0, 1'b1, 64'h100, 4'd0, 1'b1, 1'b0, 1'b0);
    check_eq("eret_inh", bus.InHandler, 64'd0);
    check_eq("eret_elr", bus.ELR_out, 64'h40);

    // One-cycle interrupt pulse at PC 0x1C.
    step(1'b0, 1'b1, 64'h1C, 4'd0, 1'b0, 1'b0, 1'b1);
    check_eq("irq_early", bus.Exc, 64'd0);
    idle(64'h1C, 1 + IRQ_EXTRA);
    check_eq("irq_ack", bus.IRQAck, 64'd1);
    check_eq("irq_elr", bus.ELR_out, 64'h1C);
    check_eq("irq_esr", bus.ESR_out, 64'd1);
    idle(64'h1C, FLUSH);
    step(1'b0, 1'b1, 64'h104, 4'd0, 1'b1, 1'b0, 1'b0);

    // Fault and interrupt in the same cycle: fault wins.
    step(1'b0, 1'b1, 64'h80, 4'd2, 1'b0, 1'b1, 1'b1);
    check_eq("sim_esr", bus.ESR_out, 64'd2);
    check_eq("sim_ack", bus.IRQAck, 64'd0);
    idle(64'h84, FLUSH);
    step(1'b0, 1'b1, 64'h108, 4'd0, 1'b1, 1'b0, 1'b0);
`ifndef EXC_IRQ_SYNC_EN
    idle(64'h80, 1);
    check_eq("sim_irq_esr", bus.ESR_out, 64'd1);
    check_eq("sim_irq_ack", bus.IRQAck, 64'd1);
    idle(64'h80, FLUSH);
    step(1'b0, 1'b1, 64'h10C, 4'd0, 1'b1, 1'b0, 1'b0);
`endif

    // ERET while running behaves as an invalid opcode.
    step(1'b0, 1'b1, 64'h200, 4'd0, 1'b1, 1'b0, 1'b0);
    check_eq("eretrun_exc", bus.Exc, 64'd1);
    check_eq("eretrun_esr", bus.ESR_out, 64'd2);
    idle(64'h204, FLUSH);

    // Double fault in the handler, interrupts ignored while locked.
    step(1'b0, 1'b1, 64'h300, 4'd2, 1'b0, 1'b1, 1'b1);
    check_eq("df_halt", bus.Halted, 64'd1);
    check_eq("df_esr", bus.ESR_out, 64'd3);
    check_eq("df_elr", bus.ELR_out, 64'h200);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 64'h304, 4'd0, 1'b0, 1'b0, 1'b1);
    check_eq("df_still", bus.Halted, 64'd1);
    step(1'b1, 1'b0, 64'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    check_eq("df_rst_halt", bus.Halted, 64'd0);
    check_eq("df_rst_elr", bus.ELR_out, 64'd0);

    // Reset during the second flush cycle.
    step(1'b0, 1'b1, 64'h500, 4'd2, 1'b0, 1'b1, 1'b0);
    idle(64'h504, 1);
    check_eq("drain_flush", bus.Flush, 64'd1);
    step(1'b1, 1'b0, 64'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    check_eq("drain_rst_flush", bus.Flush, 64'd0);
    check_eq("drain_rst_esr", bus.ESR_out, 64'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      v  = ($urandom_range(0, 3) != 0);
      na = ($urandom_range(0, 9) == 0);
      er = !na && ($urandom_range(0, 7) == 0);
      iq = ($urandom_range(0, 11) == 0);
      step(r, v, {$urandom, $urandom}, na ? 4'd2 : 4'd0, er, na, iq);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception control unit directly downstream of the main decoder.
- Consumes the decoder's EStatus, ERet and NotAnInstr plus the external interrupt line.
- Captures the faulting or interrupted PC into ELR and the cause into ESR.
- Redirects fetch to the exception vector, flushes the pipeline and tracks handler mode until ERET.
- Its ELR/ESR outputs feed the MRS read path and the ERET branch target mux.

Parameters:
- N, 64, PC/ELR width in bits.
- EXC_VECTOR, 64'h0000_0000_0000_00D8, handler entry address driven on ExcVector.
- FLUSH_CYCLES, 2, number of cycles Flush stays asserted per exception entry (legal range 1..7).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- Valid  in  1  decode stage holds a real (non-bubble) instruction.
- PC_D  in  N  PC of the instruction currently in decode.
- EStatus  in  4  cause from decoder: 0000 none, 0010 invalid opcode.
- ERet  in  1  decoder flags ERET.
- NotAnInstr  in  1  decoder flags invalid opcode.
- ExtIRQ  in  1  level-sensitive external interrupt request.
- Exc  out  1  one-cycle pulse: PC mux selects ExcVector.
- ExcVector  out  N  constant EXC_VECTOR.
- ELR_out  out  N  exception link register.
- ESR_out  out  4  exception syndrome register.
- Flush  out  1  squash IF/ID and ID/EX contents.
- IRQAck  out  1  one-cycle acknowledge of a taken interrupt.
- InHandler  out  1  high while in HANDLER state.
- Halted  out  1  double-fault lock.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: state=RUN, ELR_out=0, ESR_out=0000, Exc=0, Flush=0, IRQAck=0, InHandler=0, Halted=0, irq_pend=0, flush counter=0.
- Reset asserted mid-sequence (TAKE, DRAIN, HANDLER or HALT) returns to RUN the following cycle with all reset values; it overrides every other event.
- irq_pend register: set when ExtIRQ=1 and state is RUN; cleared when the interrupt is taken. ExtIRQ is ignored outside RUN.
- Inputs are qualified by Valid; all decoder inputs are ignored when Valid=0.
- States: RUN, TAKE, DRAIN, HANDLER, HALT.
- RUN:
  - Valid & NotAnInstr -> next edge: ELR<=PC_D, ESR<=EStatus (0010), state<=TAKE.
  - Else if irq_pend -> ELR<=PC_D (the interrupted instruction restarts after ERET), ESR<=0001, state<=TAKE. IRQAck=1 in TAKE for this case only.
  - Valid & ERet while in RUN is illegal -> handled as an invalid opcode: ELR<=PC_D, ESR<=0010, state<=TAKE.
  - If the synchronous fault and irq_pend coincide, the synchronous fault wins; irq_pend stays set.
- TAKE (1 cycle): Exc=1, Flush=1, counter<=FLUSH_CYCLES-1. If FLUSH_CYCLES=1, next state is HANDLER; otherwise DRAIN.
- DRAIN: Flush=1. Counter decrements each cycle; at 1 -> HANDLER.
  - Exception latency: fault in decode at cycle t -> Exc at t+1 -> InHandler at t+1+FLUSH_CYCLES.
- HANDLER: InHandler=1; IRQs are masked (irq_pend not set).
  - Valid & ERet -> RUN next edge. InHandler drops the same edge. ELR/ESR hold their values (readable by MRS).
  - Valid & NotAnInstr -> HALT (double fault). ESR<=0011; ELR is unchanged.
- HALT: Halted=1 and Flush=1 permanently; only reset exits.
- Outputs are Moore from state except ExcVector (constant).
- ELR and ESR change only on the entry edges listed above.

Optional Feature:
- Macro: EXC_IRQ_SYNC_EN.
- Defined: ExtIRQ passes through a two-flop synchronizer (both flops reset to 0) before the irq_pend logic. IRQ-to-Exc latency grows by 2 cycles.
- Undefined: ExtIRQ feeds the irq_pend logic directly. Minimum IRQ-to-Exc latency is 2 cycles (set irq_pend, then TAKE).

Test Plan:
- Invalid opcode: Valid=1, NotAnInstr=1, EStatus=0010, PC_D=0x40 -> next cycle Exc=1, Flush=1, ELR=0x40, ESR=0010; Flush high 2 cycles; InHandler=1 at the 3rd cycle after the fault.
- IRQ: ExtIRQ pulsed 1 cycle in RUN, PC_D=0x1C, no fault -> TAKE with IRQAck=1, ELR=0x1C, ESR=0001; with EXC_IRQ_SYNC_EN defined, Exc arrives 2 cycles later.
- Simultaneous: NotAnInstr and ExtIRQ in the same cycle, PC_D=0x80 -> ESR=0010 taken first. After ERET to RUN, the pending IRQ is taken with ESR=0001.
- ERET in handler: HANDLER, Valid=1, ERet=1 -> InHandler=0 next cycle, ELR unchanged; ERet in RUN -> ESR=0010, Exc pulse.
- Double fault: HANDLER plus NotAnInstr -> Halted=1, ESR=0011, ELR unchanged; ExtIRQ ignored. Reset=1 for one cycle -> all outputs back to reset values.
- Reset during DRAIN: reset at the 2nd Flush cycle -> next cycle Flush=0, state RUN, ELR=0, ESR=0000.
